// File: rtl/bk_multiword_seq_pkg.sv
// Shared constants and helpers for the multi-word add/subtract sequencer.
package bk_pkg;

    localparam int unsigned BK_W = 16;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // Word index width; clamped to 1 so the index register is never zero-width.
    function automatic int unsigned idx_w(input int unsigned words);
        return (words < 2) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/bk_multiword_seq_if.sv
// Request/response bus of bk_multiword_seq. req_sub exists only when BK_SUB_EN is defined.
interface bk_multiword_seq_if #(
    parameter int unsigned WORDS = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic [16*WORDS-1:0]   req_a;
    logic [16*WORDS-1:0]   req_b;
    logic                  req_cin;
`ifdef BK_SUB_EN
    logic                  req_sub;
`endif
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [16*WORDS-1:0]   rsp_sum;
    logic                  rsp_cout;
    logic                  busy;

    modport slave (
`ifdef BK_SUB_EN
        input  req_sub,
`endif
        input  req_valid, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_cout, busy
    );

    modport master (
`ifdef BK_SUB_EN
        output req_sub,
`endif
        output req_valid, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_cout, busy
    );
endinterface

// File: rtl/bk_multiword_seq_adder.sv
// 16-bit Brent-Kung prefix adder with carry-in and carry-out.
module Brentkung_adder (
    input  logic [15:0] X,
    input  logic [15:0] Y,
    input  logic        Cin,
    output logic        Cout,
    output logic [15:0] SUM
);
    logic [15:0] w_p;
    logic [15:0] w_gg;
    logic [15:0] w_pp;

    always_comb begin
        w_p  = X ^ Y;
        w_gg = X & Y;
        w_pp = w_p;
        // Fold Cin into bit 0 so every prefix G[i] is the carry out of bit i.
        w_gg[0] = w_gg[0] | (w_p[0] & Cin);
        for (int d = 1; d < 16; d = d * 2) begin
            for (int i = 2 * d - 1; i < 16; i = i + 2 * d) begin
                w_gg[i] = w_gg[i] | (w_pp[i] & w_gg[i-d]);
                w_pp[i] = w_pp[i] & w_pp[i-d];
            end
        end
        for (int d = 4; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < 16; i = i + 2 * d) begin
                w_gg[i] = w_gg[i] | (w_pp[i] & w_gg[i-d]);
                w_pp[i] = w_pp[i] & w_pp[i-d];
            end
        end
        SUM[0] = w_p[0] ^ Cin;
        for (int i = 1; i < 16; i++) begin
            SUM[i] = w_p[i] ^ w_gg[i-1];
        end
        Cout = w_gg[15];
    end
endmodule

// File: rtl/bk_multiword_seq.sv
// Sequences a WORDS x 16-bit add (or subtract with BK_SUB_EN) through one Brent-Kung adder,
// LSW first, chaining the carry between words.
module bk_multiword_seq
    import bk_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input logic               clk,
    input logic               rst_n,
    bk_multiword_seq_if.slave bus
);
    localparam int unsigned IdxW = idx_w(WORDS);
    localparam int unsigned OpW  = BK_W * WORDS;

    logic [1:0]      r_state;
    logic [IdxW-1:0] r_idx;
    logic            r_carry;
    logic [OpW-1:0]  r_a;
    logic [OpW-1:0]  r_b;
    logic [OpW-1:0]  r_sum;
    logic            r_cout;
`ifdef BK_SUB_EN
    logic            r_sub;
`endif

    logic [BK_W-1:0] w_x;
    logic [BK_W-1:0] w_y;
    logic [BK_W-1:0] w_sum;
    logic            w_cout;
    logic            w_last;
    logic            w_init_carry;

    always_comb begin
        w_x    = r_a[r_idx*BK_W +: BK_W];
        w_y    = r_b[r_idx*BK_W +: BK_W];
        w_last = (r_idx == IdxW'(WORDS - 1));
`ifdef BK_SUB_EN
        if (r_sub) w_y = ~w_y;
        w_init_carry = bus.req_sub ? 1'b1 : bus.req_cin;
`else
        w_init_carry = bus.req_cin;
`endif
    end

    Brentkung_adder u_adder (
        .X    (w_x),
        .Y    (w_y),
        .Cin  (r_carry),
        .Cout (w_cout),
        .SUM  (w_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
`ifdef BK_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.req_valid) begin
                        r_a     <= bus.req_a;
                        r_b     <= bus.req_b;
                        r_idx   <= '0;
                        r_carry <= w_init_carry;
`ifdef BK_SUB_EN
                        r_sub   <= bus.req_sub;
`endif
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    r_sum[r_idx*BK_W +: BK_W] <= w_sum;
                    r_carry <= w_cout;
                    if (w_last) begin
                        r_cout  <= w_cout;
                        r_idx   <= '0;
                        r_state <= StDone;
                    end else begin
                        r_idx <= r_idx + IdxW'(1);
                    end
                end
                StDone: begin
                    if (bus.rsp_ready) r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.req_ready = (r_state == StIdle);
    assign bus.rsp_valid = (r_state == StDone);
    assign bus.busy      = (r_state != StIdle);
    assign bus.rsp_sum   = r_sum;
    assign bus.rsp_cout  = r_cout;
endmodule

// File: tb/tb_bk_multiword_seq.sv
// Directed bench for bk_multiword_seq (WORDS=4); subtract vectors run only with BK_SUB_EN.
module tb_bk_multiword_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    bk_multiword_seq_if #(.WORDS(4)) bus ();

    bk_multiword_seq #(.WORDS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input logic [63:0] a, input logic [63:0] b, input logic cin,
                             input logic sub);
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_cin   = cin;
`ifdef BK_SUB_EN
        bus.req_sub   = sub;
`else
        if (sub) $display("[TB] subtract requested without BK_SUB_EN");
`endif
    endtask

    // Issues one request from IDLE, returns the result and edges from accept to rsp_valid.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                         input logic sub, output logic [63:0] sum, output logic cout,
                         output int lat);
        drive_req(a, b, cin, sub);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_a     = '1;
        bus.req_b     = '1;
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        sum  = bus.rsp_sum;
        cout = bus.rsp_cout;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    logic [63:0] sum;
    logic        cout;
    int          lat;
    logic        seen_valid;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = 1'b0;
        bus.rsp_ready = 1'b0;
`ifdef BK_SUB_EN
        bus.req_sub   = 1'b0;
`endif
        #12;
        check_eq("rst_req_ready", bus.req_ready, 1);
        check_eq("rst_rsp_valid", bus.rsp_valid, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_rsp_sum", bus.rsp_sum, 0);
        check_eq("rst_rsp_cout", bus.rsp_cout, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(64'd20, 64'd87, 1'b1, 1'b0, sum, cout, lat);
        check_eq("small_sum", sum, 64'd108);
        check_eq("small_cout", cout, 0);
        check_eq("small_latency", lat, 4);

        do_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, sum, cout, lat);
        check_eq("ripple_sum", sum, 64'h0000_0000_0001_0000);
        check_eq("ripple_cout", cout, 0);

        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, sum, cout, lat);
        check_eq("wrap_sum", sum, 64'd0);
        check_eq("wrap_cout", cout, 1);
        check_eq("wrap_latency", lat, 4);

        // Backpressure with a second request queued on req_valid.
        drive_req(64'd25000, 64'd4801, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive_req(64'd1, 64'd2, 1'b0, 1'b0);
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("bp_latency", lat, 4);
        for (int c = 0; c < 5; c++) begin
            check_eq($sformatf("bp_valid_%0d", c), bus.rsp_valid, 1);
            check_eq($sformatf("bp_sum_%0d", c), bus.rsp_sum, 64'd29801);
            check_eq($sformatf("bp_req_ready_%0d", c), bus.req_ready, 0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check_eq("bp_post_valid", bus.rsp_valid, 0);
        check_eq("bp_post_req_ready", bus.req_ready, 1);
        check_eq("bp_post_busy", bus.busy, 0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check_eq("bp_second_accepted", bus.busy, 1);
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("bp_second_sum", bus.rsp_sum, 64'd3);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;

        // Reset two cycles after accept.
        drive_req(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b1, 1'b0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", bus.busy, 0);
        check_eq("mid_rst_req_ready", bus.req_ready, 1);
        check_eq("mid_rst_rsp_valid", bus.rsp_valid, 0);
        check_eq("mid_rst_rsp_sum", bus.rsp_sum, 0);
        check_eq("mid_rst_rsp_cout", bus.rsp_cout, 0);
        #4;
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen_valid = 1'b1;
        end
        check_eq("mid_rst_no_rsp", seen_valid, 0);
        do_op(64'd7, 64'd6, 1'b1, 1'b0, sum, cout, lat);
        check_eq("post_rst_sum", sum, 64'd14);
        check_eq("post_rst_cout", cout, 0);

`ifdef BK_SUB_EN
        do_op(64'd25000, 64'd4801, 1'b0, 1'b1, sum, cout, lat);
        check_eq("sub_sum", sum, 64'd20199);
        check_eq("sub_cout", cout, 1);
        do_op(64'd7, 64'd8, 1'b1, 1'b1, sum, cout, lat);
        check_eq("sub_neg_sum", sum, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("sub_neg_cout", cout, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bk_multiword_seq.md
# bk_multiword_seq

Multi-word add/subtract sequencer that time-shares one 16-bit `Brentkung_adder` across the words of a wide operand. It accepts a `WORDS`×16-bit request over a valid/ready handshake and drives the adder one 16-bit word per cycle, LSW first, chaining `Cout` back into `Cin`. It returns the full-width sum and final carry over a second valid/ready handshake. The block sits between the wide-arithmetic requester and the existing 16-bit adder datapath, so wide adds need no second adder.

## Interface
- `WORDS`, default 4: number of 16-bit words per operand. Legal range 2..16. Operand width is `16*WORDS`.
- `clk`, input, 1: sole clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `req_valid`, input, 1: request present.
- `req_ready`, output, 1: block can accept a request.
- `req_a`, input, `16*WORDS`: operand A.
- `req_b`, input, `16*WORDS`: operand B.
- `req_cin`, input, 1: carry-in to the least-significant word. Ignored for subtract.
- `req_sub`, input, 1: 1 selects A−B. The port exists only with `BK_SUB_EN`.
- `rsp_valid`, output, 1: result present.
- `rsp_ready`, input, 1: consumer accepts the result.
- `rsp_sum`, output, `16*WORDS`: result.
- `rsp_cout`, output, 1: carry out of the most-significant word. For subtract, 1 means no borrow.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
- State machine has three states:
  - **IDLE**: `req_ready`=1. On `req_valid && req_ready`:
    - latch A and B;
    - set `idx`=0;
    - set `carry`=`req_cin`, or 1 when subtracting;
    - move to RUN.
  - **RUN**: the adder sees `X=A[idx]`, `Y=B[idx]` (or `~B[idx]` when subtracting) and `Cin=carry`. Each cycle:
    - `rsp_sum[idx]` <= `SUM`;
    - `carry` <= `Cout`;
    - `idx` <= `idx`+1.
    - When `idx==WORDS-1`, `rsp_cout` <= `Cout` and the state moves to DONE.
  - **DONE**: `rsp_valid`=1, and `rsp_sum`/`rsp_cout` are held stable. On `rsp_ready`, move to IDLE.
- Arithmetic is modulo 2^(16*WORDS). Overflow appears only through `rsp_cout`. There is no signed-overflow flag.
- Operands are latched at accept, so the requester may change `req_a`/`req_b` freely after the handshake.
- `req_ready` is 0 in RUN and DONE. New requests are not accepted while a result is pending.
- `rsp_sum` words from a previous operation remain visible until overwritten. Consumers must qualify them with `rsp_valid`.

## Timing
- Reset values:
  - state IDLE;
  - `req_ready`=1 (combinational from IDLE);
  - `rsp_valid`=0, `busy`=0, `rsp_cout`=0;
  - `rsp_sum`=0, `idx`=0, `carry`=0.
- Latency: with the accept edge as E0, word k is captured at edge E(k+1). `rsp_valid` rises after edge E(WORDS). With WORDS=4, `rsp_valid` is high in the 4th cycle after the accept edge.
- Minimum request-to-request spacing is WORDS+2 cycles, assuming `rsp_ready` is held at 1.
- Handshakes:
  - a transfer occurs when valid and ready are both high at a rising edge;
  - `rsp_valid` must not drop before `rsp_ready`;
  - `rsp_valid` does not depend combinationally on `rsp_ready`.
- `req_valid` asserted while busy is not an error. The request simply waits.
- `rsp_ready` is ignored outside DONE.
- Reset asserted mid-operation: all registers clear immediately to the reset values. The in-flight operation is discarded and no response is produced.
- Adder path: one full 16-bit Brent-Kung delay plus the operand mux must meet the cycle time. `Cout` is registered every cycle; there is no multi-cycle path.

## Configuration
- `BK_SUB_EN` defined:
  - the `req_sub` port exists and is latched at accept;
  - subtract inverts each B word and forces the initial carry to 1;
  - `req_cin` is ignored.
- `BK_SUB_EN` undefined:
  - `req_sub` is absent;
  - the B words feed the adder directly;
  - the initial carry is always `req_cin`.

## Structure
- Shared package `bk_pkg`:
  - `BK_W`=16;
  - state enum {IDLE, RUN, DONE};
  - the `idx` width function `$clog2(WORDS)`.
- One sub-module instance: the existing `Brentkung_adder` with ports X, Y, Cin, Cout, SUM. Word muxing, carry register and FSM stay in this module.

## Test plan
- Small add with WORDS=4: A=20, B=87, cin=1 → `rsp_sum`=108 and `rsp_cout`=0. `rsp_valid` rises exactly 4 cycles after the accept edge.
- Carry ripple across words: A=0x0000_0000_0000_FFFF, B=1, cin=0 → `rsp_sum`=0x0000_0000_0001_0000, `rsp_cout`=0.
- Full wrap: A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1 → `rsp_sum`=0, `rsp_cout`=1.
- Backpressure: complete the A=25000, B=4801 add and hold `rsp_ready`=0 for 5 cycles. Required response:
  - `rsp_valid`=1 and `rsp_sum`=29801, both stable throughout;
  - `req_ready`=0 throughout;
  - a second request held on `req_valid` is accepted only in the cycle after the response transfers.
- Reset mid-op: drop `rst_n` two cycles after accept → all outputs take their reset values asynchronously. After release, no response appears and the next request (7+6, cin=1) returns 14.
- Subtract, `BK_SUB_EN` defined only:
  - 25000−4801 → `rsp_sum`=20199, `rsp_cout`=1;
  - 7−8 → `rsp_sum`=0xFFFF_FFFF_FFFF_FFFF, `rsp_cout`=0.
